// File: rtl/bubble_pkg.sv
// Shared types, defaults and size-derived helpers for the bubble trajectory engine.
package bubble_pkg;

  localparam int FRAME_W_DEF   = 640;
  localparam int FRAME_H_DEF   = 480;
  localparam int FRAC_BITS_DEF = 6;
  localparam int N_SIZES_DEF   = 4;
  localparam int SW            = (N_SIZES_DEF > 1) ? $clog2(N_SIZES_DEF) : 1;

  typedef enum logic [1:0] {IDLE, MOVE, POP} state_t;
  typedef logic [SW-1:0] size_t;

  function automatic int diam(input int s, input int base);
    return base << s;
  endfunction

  function automatic int bounceSpeed(input int s, input int base, input int step);
    return base + s * step;
  endfunction

endpackage

// File: rtl/bubble_if.sv
// Manager-to-bubble bus: launch/hit controls in, position and pop/split events out.
// The freeze input exists only when BUBBLE_FREEZE_EN is defined.
interface bubble_if #(parameter int SW = bubble_pkg::SW);
  logic          startOfFrame;
  logic          spawn;
  logic [10:0]   spawnX;
  logic [10:0]   spawnY;
  logic [SW-1:0] spawnSize;
  logic          spawnDirLeft;
  logic          spawnUp;
  logic          hit;
`ifdef BUBBLE_FREEZE_EN
  logic          freeze;
`endif
  logic [10:0]   topLeftX;
  logic [10:0]   topLeftY;
  logic [SW-1:0] size;
  logic          active;
  logic          popping;
  logic          popDone;
  logic          splitReq;
  logic [SW-1:0] childSize;
  logic [10:0]   childX;
  logic [10:0]   childY;

  modport master (
`ifdef BUBBLE_FREEZE_EN
    output freeze,
`endif
    output startOfFrame, spawn, spawnX, spawnY, spawnSize, spawnDirLeft, spawnUp, hit,
    input  topLeftX, topLeftY, size, active, popping, popDone, splitReq,
    input  childSize, childX, childY
  );

  modport slave (
`ifdef BUBBLE_FREEZE_EN
    input  freeze,
`endif
    input  startOfFrame, spawn, spawnX, spawnY, spawnSize, spawnDirLeft, spawnUp, hit,
    output topLeftX, topLeftY, size, active, popping, popDone, splitReq,
    output childSize, childX, childY
  );
endinterface

// File: rtl/bubble_axis_step.sv
// Single-axis fixed-point integrator: pos + vel, with wall detection and a [0, max] clamp.
module bubble_axis_step #(
  parameter int PW = 18
) (
  input  logic signed [PW-1:0] i_pos,
  input  logic signed [PW-1:0] i_vel,
  input  logic signed [PW-1:0] i_max,
  output logic signed [PW-1:0] o_sum,
  output logic signed [PW-1:0] o_clamped,
  output logic                 o_low_hit,
  output logic                 o_high_hit
);
  logic signed [PW:0] w_sum_ext;
  logic signed [PW:0] w_max_ext;

  // One guard bit so the wall comparisons see the true sign of the sum.
  assign w_sum_ext  = $signed({i_pos[PW-1], i_pos}) + $signed({i_vel[PW-1], i_vel});
  assign w_max_ext  = $signed({i_max[PW-1], i_max});
  assign o_low_hit  = w_sum_ext[PW] || (w_sum_ext == '0);
  assign o_high_hit = (w_sum_ext >= w_max_ext);
  assign o_sum      = w_sum_ext[PW-1:0];
  assign o_clamped  = o_low_hit ? '0 : (o_high_hit ? i_max : o_sum);
endmodule

// File: rtl/bubble_move.sv
// Per-bubble trajectory engine: spawn, per-frame motion with wall/floor bounces, pop and split.
// Optional BUBBLE_FREEZE_EN adds bus.freeze, which suspends frame updates in MOVE and POP.
module bubble_move
  import bubble_pkg::*;
#(
  parameter int FRAME_W     = FRAME_W_DEF,
  parameter int FRAME_H     = FRAME_H_DEF,
  parameter int FRAC_BITS   = FRAC_BITS_DEF,
  parameter int N_SIZES     = N_SIZES_DEF,
  parameter int BASE_DIAM   = 8,
  parameter int X_SPEED     = 64,
  parameter int GRAVITY     = 1,
  parameter int BOUNCE_BASE = 256,
  parameter int BOUNCE_STEP = 64,
  parameter int SPLIT_VY    = 128,
  parameter int POP_FRAMES  = 8
) (
  input logic     clk,
  input logic     resetN,
  bubble_if.slave bus
);
  localparam int SZW = (N_SIZES > 1) ? $clog2(N_SIZES) : 1;
  localparam int PW  = 12 + FRAC_BITS;
  localparam int CW  = (POP_FRAMES > 1) ? $clog2(POP_FRAMES) : 1;

  typedef logic signed [PW-1:0] fx_t;

  localparam fx_t            X_SPD    = fx_t'(X_SPEED);
  localparam fx_t            GRAV     = fx_t'(GRAVITY);
  localparam fx_t            UP_VY    = fx_t'(-SPLIT_VY);
  localparam logic [CW-1:0]  CNT_LAST = CW'(POP_FRAMES - 1);

  state_t         r_state, w_state_next;
  fx_t            r_x, r_y, r_vx, r_vy;
  fx_t            w_x_next, w_y_next, w_vx_next, w_vy_next;
  logic [SZW-1:0] r_size, w_size_next;
  logic [CW-1:0]  r_cnt, w_cnt_next;
  logic           r_pop_done, w_pop_done_next;
  logic           r_split, w_split_next;

  fx_t w_xmax_tab   [N_SIZES];
  fx_t w_ymax_tab   [N_SIZES];
  fx_t w_bounce_tab [N_SIZES];
  fx_t w_xmax, w_ymax, w_bounce;

  // Per-size limits and rebound speeds are constants; the live size just selects a row.
  generate
    for (genvar gi = 0; gi < N_SIZES; gi++) begin : g_size
      assign w_xmax_tab[gi]   = fx_t'((FRAME_W - diam(gi, BASE_DIAM)) << FRAC_BITS);
      assign w_ymax_tab[gi]   = fx_t'((FRAME_H - diam(gi, BASE_DIAM)) << FRAC_BITS);
      assign w_bounce_tab[gi] = fx_t'(-bounceSpeed(gi, BOUNCE_BASE, BOUNCE_STEP));
    end
  endgenerate

  assign w_xmax   = w_xmax_tab[r_size];
  assign w_ymax   = w_ymax_tab[r_size];
  assign w_bounce = w_bounce_tab[r_size];

  fx_t  w_x_sum, w_x_clamped, w_y_sum, w_y_clamped;
  logic w_x_low, w_x_high, w_y_low, w_y_high;

  bubble_axis_step #(.PW(PW)) u_axis_x (
    .i_pos(r_x), .i_vel(r_vx), .i_max(w_xmax),
    .o_sum(w_x_sum), .o_clamped(w_x_clamped), .o_low_hit(w_x_low), .o_high_hit(w_x_high)
  );

  bubble_axis_step #(.PW(PW)) u_axis_y (
    .i_pos(r_y), .i_vel(r_vy), .i_max(w_ymax),
    .o_sum(w_y_sum), .o_clamped(w_y_clamped), .o_low_hit(w_y_low), .o_high_hit(w_y_high)
  );

  logic w_sof;
`ifdef BUBBLE_FREEZE_EN
  assign w_sof = bus.startOfFrame & ~bus.freeze;
`else
  assign w_sof = bus.startOfFrame;
`endif

  logic w_vx_neg, w_vx_pos, w_vy_neg;
  assign w_vx_neg = r_vx[PW-1];
  assign w_vx_pos = !r_vx[PW-1] && (r_vx != '0);
  assign w_vy_neg = r_vy[PW-1];

  always_comb begin
    w_state_next    = r_state;
    w_x_next        = r_x;
    w_y_next        = r_y;
    w_vx_next       = r_vx;
    w_vy_next       = r_vy;
    w_size_next     = r_size;
    w_cnt_next      = r_cnt;
    w_pop_done_next = 1'b0;
    w_split_next    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.spawn) begin
          w_state_next = MOVE;
          w_x_next     = fx_t'(bus.spawnX) <<< FRAC_BITS;
          w_y_next     = fx_t'(bus.spawnY) <<< FRAC_BITS;
          w_size_next  = bus.spawnSize;
          w_vx_next    = bus.spawnDirLeft ? -X_SPD : X_SPD;
          w_vy_next    = bus.spawnUp ? UP_VY : '0;
        end
      end
      MOVE: begin
        if (bus.hit) begin
          w_state_next = POP;
          w_cnt_next   = '0;
        end else if (w_sof) begin
          if ((w_x_low && w_vx_neg) || (w_x_high && w_vx_pos)) begin
            w_x_next  = w_x_clamped;
            w_vx_next = w_vx_neg ? X_SPD : -X_SPD;
          end else begin
            w_x_next  = w_x_sum;
          end
          // Floor rebound is a fixed per-size speed, so bounce height never decays.
          if (w_y_high && !w_vy_neg) begin
            w_y_next  = w_y_clamped;
            w_vy_next = w_bounce;
          end else if (w_y_low && w_vy_neg) begin
            w_y_next  = w_y_clamped;
            w_vy_next = '0;
          end else begin
            w_y_next  = w_y_sum;
            w_vy_next = r_vy + GRAV;
          end
        end
      end
      POP: begin
        if (w_sof) begin
          if (r_cnt == CNT_LAST) begin
            w_state_next    = IDLE;
            w_pop_done_next = 1'b1;
            w_split_next    = (r_size != '0);
          end else begin
            w_cnt_next = r_cnt + CW'(1);
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state    <= IDLE;
      r_x        <= '0;
      r_y        <= '0;
      r_vx       <= '0;
      r_vy       <= '0;
      r_size     <= '0;
      r_cnt      <= '0;
      r_pop_done <= 1'b0;
      r_split    <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_x        <= w_x_next;
      r_y        <= w_y_next;
      r_vx       <= w_vx_next;
      r_vy       <= w_vy_next;
      r_size     <= w_size_next;
      r_cnt      <= w_cnt_next;
      r_pop_done <= w_pop_done_next;
      r_split    <= w_split_next;
    end
  end

  assign bus.topLeftX  = r_x[FRAC_BITS +: 11];
  assign bus.topLeftY  = r_y[FRAC_BITS +: 11];
  assign bus.size      = r_size;
  assign bus.active    = (r_state != IDLE);
  assign bus.popping   = (r_state == POP);
  assign bus.popDone   = r_pop_done;
  assign bus.splitReq  = r_split;
  // Child fields are gated so every output reads zero outside a split pulse.
  assign bus.childSize = r_split ? (r_size - SZW'(1)) : '0;
  assign bus.childX    = r_split ? bus.topLeftX : '0;
  assign bus.childY    = r_split ? bus.topLeftY : '0;
endmodule

// File: tb/tb_bubble_move.sv
// Directed bench for bubble_move: a vector table for single-cycle behaviour plus
// hand sequences for reset during POP, freeze (BUBBLE_FREEZE_EN) and repeated floor bounces.
module tb_bubble_move;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;

  bubble_if #(.SW(SW)) bus ();
  bubble_move dut (.clk(clk), .resetN(resetN), .bus(bus));

  typedef struct packed {
    logic          sof;
    logic          spw;
    logic          hit;
    logic [10:0]   sx;
    logic [10:0]   sy;
    logic [SW-1:0] ssz;
    logic          left;
    logic          up;
    logic [51:0]   exp;
  } vec_t;

  vec_t tab[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Output tuple: X, Y, size, active, popping, popDone, splitReq, childSize, childX, childY.
  function automatic logic [51:0] pk(int x, int y, int sz, bit a, bit p, bit d, bit s);
    logic [10:0]   cx;
    logic [10:0]   cy;
    logic [SW-1:0] cs;
    cx = s ? 11'(x) : 11'd0;
    cy = s ? 11'(y) : 11'd0;
    cs = s ? SW'(sz - 1) : '0;
    return {11'(x), 11'(y), SW'(sz), a, p, d, s, cs, cx, cy};
  endfunction

  function automatic logic [51:0] dut_out();
    return {bus.topLeftX, bus.topLeftY, bus.size, bus.active, bus.popping, bus.popDone,
            bus.splitReq, bus.childSize, bus.childX, bus.childY};
  endfunction

  function automatic vec_t mkv(bit sof, bit spw, bit hit, int sx, int sy, int sz,
                               bit left, bit up, logic [51:0] e);
    vec_t v;
    v.sof = sof; v.spw = spw; v.hit = hit;
    v.sx = 11'(sx); v.sy = 11'(sy); v.ssz = SW'(sz);
    v.left = left; v.up = up; v.exp = e;
    return v;
  endfunction

  // Seven held POP frames, the eighth ends the pop, then one quiet cycle.
  function automatic void add_pop(int x, int y, int sz);
    for (int i = 0; i < 7; i++) tab.push_back(mkv(1, 0, 0, 0, 0, 0, 0, 0, pk(x, y, sz, 1, 1, 0, 0)));
    tab.push_back(mkv(1, 0, 0, 0, 0, 0, 0, 0, pk(x, y, sz, 0, 0, 1, sz > 0)));
    tab.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, pk(x, y, sz, 0, 0, 0, 0)));
  endfunction

  task automatic check(input string name, input logic [51:0] got, input logic [51:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string name);
    bus.startOfFrame = v.sof;
    bus.spawn        = v.spw;
    bus.hit          = v.hit;
    bus.spawnX       = v.sx;
    bus.spawnY       = v.sy;
    bus.spawnSize    = v.ssz;
    bus.spawnDirLeft = v.left;
    bus.spawnUp      = v.up;
    @(posedge clk);
    #1;
    bus.startOfFrame = 1'b0;
    bus.spawn        = 1'b0;
    bus.hit          = 1'b0;
    check(name, dut_out(), v.exp);
  endtask

  int          bq[$];
  logic [10:0] yv;
  bit          prev_b;

  initial begin
    bus.startOfFrame = 1'b0; bus.spawn = 1'b0; bus.hit = 1'b0;
    bus.spawnX = '0; bus.spawnY = '0; bus.spawnSize = '0;
    bus.spawnDirLeft = 1'b0; bus.spawnUp = 1'b0;
`ifdef BUBBLE_FREEZE_EN
    bus.freeze = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", dut_out(), '0);
    resetN = 1'b1;

    tab.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0)));
    tab.push_back(mkv(0, 1, 0, 100, 100, 0, 0, 0, pk(100, 100, 0, 1, 0, 0, 0)));
    tab.push_back(mkv(1, 0, 0, 0, 0, 0, 0, 0, pk(101, 100, 0, 1, 0, 0, 0)));
    tab.push_back(mkv(1, 0, 0, 0, 0, 0, 0, 0, pk(102, 100, 0, 1, 0, 0, 0)));
    tab.push_back(mkv(0, 0, 1, 0, 0, 0, 0, 0, pk(102, 100, 0, 1, 1, 0, 0)));
    tab.push_back(mkv(0, 1, 0, 300, 300, 1, 1, 1, pk(102, 100, 0, 1, 1, 0, 0)));
    add_pop(102, 100, 0);
    tab.push_back(mkv(0, 0, 1, 0, 0, 0, 0, 0, pk(102, 100, 0, 0, 0, 0, 0)));
    tab.push_back(mkv(0, 1, 1, 631, 200, 0, 0, 0, pk(631, 200, 0, 1, 0, 0, 0)));
    tab.push_back(mkv(1, 0, 0, 0, 0, 0, 0, 0, pk(632, 200, 0, 1, 0, 0, 0)));
    tab.push_back(mkv(1, 0, 0, 0, 0, 0, 0, 0, pk(631, 200, 0, 1, 0, 0, 0)));
    tab.push_back(mkv(1, 0, 0, 0, 0, 0, 0, 0, pk(630, 200, 0, 1, 0, 0, 0)));
    tab.push_back(mkv(1, 0, 1, 0, 0, 0, 0, 0, pk(630, 200, 0, 1, 1, 0, 0)));
    add_pop(630, 200, 0);
    tab.push_back(mkv(0, 1, 0, 200, 150, 2, 1, 1, pk(200, 150, 2, 1, 0, 0, 0)));
    tab.push_back(mkv(1, 0, 1, 0, 0, 0, 0, 0, pk(200, 150, 2, 1, 1, 0, 0)));
    add_pop(200, 150, 2);
    tab.push_back(mkv(0, 1, 0, 10, 100, 1, 1, 1, pk(10, 100, 1, 1, 0, 0, 0)));
    tab.push_back(mkv(1, 0, 0, 0, 0, 0, 0, 0, pk(9, 98, 1, 1, 0, 0, 0)));
    tab.push_back(mkv(1, 0, 0, 0, 0, 0, 0, 0, pk(8, 96, 1, 1, 0, 0, 0)));
    tab.push_back(mkv(0, 0, 1, 0, 0, 0, 0, 0, pk(8, 96, 1, 1, 1, 0, 0)));
    add_pop(8, 96, 1);
    tab.push_back(mkv(0, 1, 0, 1, 1, 1, 1, 1, pk(1, 1, 1, 1, 0, 0, 0)));
    tab.push_back(mkv(1, 0, 0, 0, 0, 0, 0, 0, pk(0, 0, 1, 1, 0, 0, 0)));
    tab.push_back(mkv(1, 0, 0, 0, 0, 0, 0, 0, pk(1, 0, 1, 1, 0, 0, 0)));

    for (int i = 0; i < tab.size(); i++) apply(tab[i], $sformatf("vec%0d", i));

    // Reset asserted in the middle of a pop.
    apply(mkv(0, 0, 1, 0, 0, 0, 0, 0, pk(1, 0, 1, 1, 1, 0, 0)), "pop_before_reset");
    apply(mkv(1, 0, 0, 0, 0, 0, 0, 0, pk(1, 0, 1, 1, 1, 0, 0)), "pop_frame1");
    apply(mkv(1, 0, 0, 0, 0, 0, 0, 0, pk(1, 0, 1, 1, 1, 0, 0)), "pop_frame2");
    #1;
    resetN = 1'b0;
    #1;
    check("reset_async", dut_out(), '0);
    bus.startOfFrame = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("reset_hold%0d", i), dut_out(), '0);
    end
    bus.startOfFrame = 1'b0;
    resetN = 1'b1;
    for (int i = 0; i < 10; i++)
      apply(mkv(1, 0, 0, 0, 0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0)), $sformatf("post_reset%0d", i));

`ifdef BUBBLE_FREEZE_EN
    apply(mkv(0, 1, 0, 300, 200, 0, 0, 0, pk(300, 200, 0, 1, 0, 0, 0)), "frz_spawn");
    bus.freeze = 1'b1;
    for (int i = 0; i < 5; i++)
      apply(mkv(1, 0, 0, 0, 0, 0, 0, 0, pk(300, 200, 0, 1, 0, 0, 0)), $sformatf("frz_move%0d", i));
    bus.freeze = 1'b0;
    apply(mkv(1, 0, 0, 0, 0, 0, 0, 0, pk(301, 200, 0, 1, 0, 0, 0)), "frz_release_move");
    bus.freeze = 1'b1;
    apply(mkv(1, 0, 1, 0, 0, 0, 0, 0, pk(301, 200, 0, 1, 1, 0, 0)), "frz_hit");
    bus.freeze = 1'b0;
    for (int i = 0; i < 3; i++)
      apply(mkv(1, 0, 0, 0, 0, 0, 0, 0, pk(301, 200, 0, 1, 1, 0, 0)), $sformatf("frz_popa%0d", i));
    bus.freeze = 1'b1;
    for (int i = 0; i < 5; i++)
      apply(mkv(1, 0, 0, 0, 0, 0, 0, 0, pk(301, 200, 0, 1, 1, 0, 0)), $sformatf("frz_pop%0d", i));
    bus.freeze = 1'b0;
    for (int i = 0; i < 4; i++)
      apply(mkv(1, 0, 0, 0, 0, 0, 0, 0, pk(301, 200, 0, 1, 1, 0, 0)), $sformatf("frz_popb%0d", i));
    apply(mkv(1, 0, 0, 0, 0, 0, 0, 0, pk(301, 200, 0, 0, 0, 1, 0)), "frz_pop_done");
`endif

    // Floor bounces of a size-0 bubble: first at frame 12, then every 431 frames.
    apply(mkv(0, 1, 0, 0, 471, 0, 0, 0, pk(0, 471, 0, 1, 0, 0, 0)), "bounce_spawn");
    prev_b = 1'b0;
    for (int f = 1; f <= 900; f++) begin
      bus.startOfFrame = 1'b1;
      @(posedge clk);
      #1;
      bus.startOfFrame = 1'b0;
      yv = bus.topLeftY;
      if (f == 11) check("pre_bounce_y", 52'(yv), 52'(471));
      if (yv == 11'd472) bq.push_back(f);
      if (prev_b) check($sformatf("rebound_y_f%0d", f), 52'(yv), 52'(468));
      prev_b = (yv == 11'd472);
    end
    check("bounce_count", 52'(bq.size()), 52'(3));
    if (bq.size() >= 3) begin
      check("first_bounce_frame", 52'(bq[0]), 52'(12));
      check("bounce_period1", 52'(bq[1] - bq[0]), 52'(431));
      check("bounce_period2", 52'(bq[2] - bq[1]), 52'(431));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/bubble_move.md
Name: bubble_move

Overview:
- Per-bubble trajectory engine for the Bubble Trouble playfield. It is the parametrised successor to the single-ball mover.
- Adds size levels, a fixed per-size bounce height, spawn/launch control, a hit/pop sequence, and a split request for child bubbles.
- A bubble manager instantiates N copies. Drawers consume topLeftX/Y and active.
- Motion updates once per frame on startOfFrame, using fixed-point with FRAC_BITS fraction bits.

Parameters:
FRAME_W, 640, playfield width in pixels
FRAME_H, 480, playfield height in pixels
FRAC_BITS, 6, fixed-point fraction bits (the multiplier is 2^FRAC_BITS)
N_SIZES, 4, number of size levels; size 0 is the smallest
BASE_DIAM, 8, size-0 diameter in pixels; diameter(s) = BASE_DIAM << s
X_SPEED, 64, horizontal speed magnitude in fixed-point units per frame
GRAVITY, 1, added to vy every frame
BOUNCE_BASE, 256, floor rebound speed for size 0
BOUNCE_STEP, 64, extra rebound speed per size level
SPLIT_VY, 128, upward speed given to a child spawned with spawnUp=1
POP_FRAMES, 8, number of frames the bubble stays frozen in POP

Ports:
clk  in  1  clock
resetN  in  1  reset, asynchronous, active-low
startOfFrame  in  1  one-cycle pulse at the start of each frame
spawn  in  1  one-cycle launch request; honoured only in IDLE
spawnX  in  11  launch top-left X in pixels
spawnY  in  11  launch top-left Y in pixels
spawnSize  in  SW=$clog2(N_SIZES)  launch size level
spawnDirLeft  in  1  1 = initial vx is -X_SPEED, 0 = +X_SPEED
spawnUp  in  1  1 = initial vy is -SPLIT_VY, 0 = initial vy is 0
hit  in  1  collision with the player's shot; honoured only in MOVE
topLeftX  out  11  current X in pixels
topLeftY  out  11  current Y in pixels
size  out  SW  current size level
active  out  1  high in MOVE and POP
popping  out  1  high in POP
popDone  out  1  one-cycle pulse when POP ends
splitReq  out  1  one-cycle pulse with popDone, only when size > 0
childSize  out  SW  size-1, valid while splitReq is high
childX  out  11  topLeftX, valid while splitReq is high
childY  out  11  topLeftY, valid while splitReq is high

Behaviour:
Reset:
- State goes to IDLE.
- All outputs are 0. Internal x, y, vx, vy and the pop counter are 0.

Arithmetic:
- x, y, vx and vy are signed, 12+FRAC_BITS bits wide.
- topLeftX/Y = x/y >>> FRAC_BITS, truncated to 11 bits.
- Clamping guarantees x and y never go negative.
- Limits: xMax = (FRAME_W - diam) << FRAC_BITS; yMax = (FRAME_H - diam) << FRAC_BITS.

IDLE:
- Outputs hold their last position; active=0.
- spawn loads:
  - x = spawnX << FRAC_BITS, y = spawnY << FRAC_BITS
  - size = spawnSize
  - vx = ±X_SPEED according to spawnDirLeft
  - vy = spawnUp ? -SPLIT_VY : 0
- Then transition to MOVE on the next cycle.
- hit is ignored in IDLE, including when it coincides with spawn.

MOVE, on startOfFrame. Compute nx = x + vx and ny = y + vy, then:
- X axis:
  - If nx <= 0 and vx < 0: x = 0, vx = +X_SPEED.
  - Else if nx >= xMax and vx > 0: x = xMax, vx = -X_SPEED.
  - Else: x = nx.
- Y axis:
  - If ny >= yMax and vy >= 0: y = yMax, vy = -(BOUNCE_BASE + size*BOUNCE_STEP). This is a fixed bounce height and does not decay. Gravity is not applied this frame.
  - Else if ny <= 0 and vy < 0: y = 0, vy = 0.
  - Else: y = ny, vy = vy + GRAVITY.
- Registers update one cycle after the startOfFrame pulse.

MOVE, on hit:
- Transition to POP and clear the pop counter.
- If hit and startOfFrame arrive together, hit wins and no motion update occurs.
- spawn is ignored in MOVE.

POP:
- Position is frozen; popping=1.
- The counter increments on each startOfFrame.
- When the counter reaches POP_FRAMES-1 and startOfFrame arrives:
  - Pulse popDone for one cycle.
  - Pulse splitReq for one cycle if size > 0, with childSize = size-1 and childX/Y = the current pixel position.
  - Transition to IDLE.
- hit and spawn are ignored in POP.

Reset asserted mid-operation:
- State goes to IDLE immediately and all outputs return to their reset values.
- No pulses are emitted.

Optional Feature:
BUBBLE_FREEZE_EN
- Defined:
  - Adds input port freeze (1 bit).
  - While freeze=1, startOfFrame is ignored in MOVE and POP: no motion and no pop counting.
  - hit is still honoured in MOVE.
  - spawn is still honoured in IDLE.
- Undefined: the freeze port is absent and the block behaves exactly as described above.

Decomposition:
Package bubble_pkg:
- state enum {IDLE, MOVE, POP}
- size type of width SW
- function diam(size)
- function bounceSpeed(size)
- shared frame-size defaults and FRAC_BITS

Sub-module bubble_axis_step:
- Combinational single-axis integrator: position + velocity, clamp to [0, max].
- Reports lowHit and highHit.
- Instantiated once for X and once for Y.
- The FSM in bubble_move chooses the new velocity.

Test Plan:
1. Reset, then spawn(X=100, Y=100, size 0, dirLeft=0, up=0), then one frame -> X=101, Y=100, active=1; vy internally = 1.
2. Spawn X=631, size 0, moving right; one frame -> X=632 (xMax), vx=-64; next frame -> X=631.
3. Spawn Y=471, size 0, up=0 -> at frame 12, Y=472 and vy=-256; frame 13 -> Y=468. The rebound height is identical across 3 consecutive bounces.
4. Spawn size 2 at (200, 150), apply hit together with startOfFrame -> no move; popping=1 for 8 frames with position held; then popDone and splitReq for one cycle, childSize=1, childX=200, childY=150, active=0.
5. Pop a size-0 bubble -> popDone=1, splitReq=0. spawn during POP -> ignored. hit during IDLE -> ignored.
6. resetN low for 3 cycles during POP -> all outputs 0, no popDone. With BUBBLE_FREEZE_EN and freeze=1 for 5 frames -> X/Y unchanged, and the pop count resumes after freeze is released.
